// File: rtl/button_conditioner.sv
// Handlebar button front end: 2-flop sync, sampled glitch filter, optional stuck release.
// Define STUCK_DETECT_EN to build the per-button stuck-hold detector.
module button_conditioner #(
    parameter int SAMPLE_DIV  = 36,
    parameter int FILTER_LEN  = 4,
    parameter int STUCK_TICKS = 10000
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       Mode_Raw,
    input  logic       Trip_Raw,
    output logic       Mode,
    output logic       Trip,
    output logic [1:0] Stuck
);

    localparam int PW = $clog2(SAMPLE_DIV);

    // Index 1 = Mode, index 0 = Trip throughout.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [FILTER_LEN-1:0] shr_q [2];
    logic [FILTER_LEN-1:0] shr_d [2];
    logic [1:0]            filt_q, filt_d;
    logic [1:0]            out_q, out_d;
    logic                  tick;

    // Synchroniser, prescaler and per-button sample filter.
    always_comb begin
        sync1_d = {Mode_Raw, Trip_Raw};
        sync2_d = sync1_q;
        tick    = (presc_q == PW'(SAMPLE_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        filt_d  = filt_q;
        for (int b = 0; b < 2; b++) begin
            shr_d[b] = shr_q[b];
            if (tick) begin
                shr_d[b] = {shr_q[b][FILTER_LEN-2:0], sync2_q[b]};
                if (&shr_d[b]) begin
                    filt_d[b] = 1'b1;
                end else if (~|shr_d[b]) begin
                    filt_d[b] = 1'b0;
                end
            end
        end
    end

`ifdef STUCK_DETECT_EN
    localparam int CW = $clog2(STUCK_TICKS + 1);
    localparam logic [CW-1:0] CMAX = CW'(STUCK_TICKS);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        STUCK
    } st_t;

    st_t           st_q  [2];
    st_t           st_d  [2];
    logic [CW-1:0] ctr_q [2];
    logic [CW-1:0] ctr_d [2];

    // Stuck detector: count ticks while pressed, force release at the limit.
    always_comb begin
        out_d = filt_d;
        for (int b = 0; b < 2; b++) begin
            st_d[b]  = st_q[b];
            ctr_d[b] = ctr_q[b];
            unique case (st_q[b])
                IDLE: begin
                    if (!filt_d[b]) begin
                        st_d[b]  = HELD;
                        ctr_d[b] = '0;
                    end
                end
                HELD: begin
                    if (filt_d[b]) begin
                        st_d[b] = IDLE;
                    end else if (tick) begin
                        if (ctr_q[b] != CMAX) begin
                            ctr_d[b] = ctr_q[b] + CW'(1);
                        end
                        if (ctr_d[b] == CMAX) begin
                            st_d[b] = STUCK;
                        end
                    end
                end
                STUCK: begin
                    ctr_d[b] = CMAX;
                    if (filt_d[b]) begin
                        st_d[b] = IDLE;
                    end
                end
                default: begin
                    st_d[b] = IDLE;
                end
            endcase
            if (st_d[b] == STUCK) begin
                out_d[b] = 1'b1;
            end
        end
    end

    // Stuck detector state registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int b = 0; b < 2; b++) begin
                st_q[b]  <= IDLE;
                ctr_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                st_q[b]  <= st_d[b];
                ctr_q[b] <= ctr_d[b];
            end
        end
    end

    assign Stuck = {st_q[1] == STUCK, st_q[0] == STUCK};
`else
    // Outputs simply follow the filter.
    always_comb begin
        out_d = filt_d;
    end

    assign Stuck = 2'b00;
`endif

    // Datapath registers; everything idles released (high).
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            presc_q <= '0;
            filt_q  <= 2'b11;
            out_q   <= 2'b11;
            for (int b = 0; b < 2; b++) begin
                shr_q[b] <= '1;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
            filt_q  <= filt_d;
            out_q   <= out_d;
            for (int b = 0; b < 2; b++) begin
                shr_q[b] <= shr_d[b];
            end
        end
    end

    assign Mode = out_q[1];
    assign Trip = out_q[0];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (SAMPLE_DIV=4, FILTER_LEN=3, STUCK_TICKS=8).
// Stuck checks are built when STUCK_DETECT_EN is defined.
module tb_button_conditioner;

    localparam int SD = 4;
    localparam int FL = 3;
    localparam int ST = 8;

    logic       HCLK     = 1'b0;
    logic       HRESETn  = 1'b0;
    logic       Mode_Raw = 1'b1;
    logic       Trip_Raw = 1'b1;
    logic       Mode;
    logic       Trip;
    logic [1:0] Stuck;

    int n_vec  = 0;
    int n_fail = 0;

    button_conditioner #(
        .SAMPLE_DIV (SD),
        .FILTER_LEN (FL),
        .STUCK_TICKS(ST)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .Mode_Raw(Mode_Raw),
        .Trip_Raw(Trip_Raw),
        .Mode    (Mode),
        .Trip    (Trip),
        .Stuck   (Stuck)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic       m;
        logic       t;
        logic       em;
        logic       et;
        logic [1:0] es;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return Trip;
            1:       return Mode;
            2:       return Stuck == 2'b00;
            default: return Mode & Trip;
        endcase
    endfunction

    // Returns edges until sel(w)==lvl, or -1 on timeout.
    task automatic wait_sig(input int w, input logic lvl, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(posedge HCLK);
            #1;
            if (sel(w) === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int low;
        int bad;

        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00};

        // Reset state
        step(3);
        check("rst_mode", Mode, 1);
        check("rst_trip", Trip, 1);
        check("rst_stuck", Stuck, 0);
        HRESETn = 1'b1;

        // Idle for 100 cycles, no toggles
        bad = 0;
        repeat (100) begin
            step(1);
            if (Mode !== 1'b1 || Trip !== 1'b1 || Stuck !== 2'b00) bad++;
        end
        check("idle_toggles", bad, 0);

        // Trip press / release latency
        Trip_Raw = 1'b0;
        wait_sig(0, 1'b0, 40, n);
        check_rng("trip_fall_lat", n, 11, 15);
        bad = 0;
        repeat (10) begin
            step(1);
            if (Trip !== 1'b0) bad++;
        end
        check("trip_stays_low", bad, 0);
        Trip_Raw = 1'b1;
        wait_sig(0, 1'b1, 40, n);
        check_rng("trip_rise_lat", n, 11, 15);
        step(5);

        // Short Mode glitches never reach the output
        bad = 0;
        repeat (20) begin
            Mode_Raw = 1'b0;
            step(1);
            if (Mode !== 1'b1) bad++;
            Mode_Raw = 1'b1;
            for (int i = 0; i < 12; i++) begin
                step(1);
                if (Mode !== 1'b1) bad++;
            end
            Mode_Raw = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step(1);
                if (Mode !== 1'b1) bad++;
            end
            Mode_Raw = 1'b1;
            for (int i = 0; i < 12; i++) begin
                step(1);
                if (Mode !== 1'b1) bad++;
            end
        end
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (Mode !== 1'b1) bad++;
        end
        check("glitch_mode_held", bad, 0);

        // Steady-level table
        for (int k = 0; k < 10; k++) begin
            Mode_Raw = vecs[k].m;
            Trip_Raw = vecs[k].t;
            step(16);
            check($sformatf("vec%0d_mode", k), Mode, vecs[k].em);
            check($sformatf("vec%0d_trip", k), Trip, vecs[k].et);
            check($sformatf("vec%0d_stuck", k), Stuck, vecs[k].es);
        end

        // Simultaneous press changes both on one edge
        Mode_Raw = 1'b0;
        Trip_Raw = 1'b0;
        wait_sig(3, 1'b0, 40, n);
        check_rng("simul_lat", n, 11, 15);
        check("simul_mode", Mode, 0);
        check("simul_trip", Trip, 0);
        Mode_Raw = 1'b1;
        Trip_Raw = 1'b1;
        step(20);
        check("simul_rel_mode", Mode, 1);
        check("simul_rel_trip", Trip, 1);

        // Long Trip hold
        Trip_Raw = 1'b0;
`ifdef STUCK_DETECT_EN
        wait_sig(0, 1'b0, 40, n);
        check_rng("hold_fall_lat", n, 11, 15);
        wait_sig(0, 1'b1, 100, low);
        check("stuck_low_cycles", low, ST * SD);
        check("stuck_set", Stuck, 2'b01);
        step(200 - n - low);
        check("stuck_trip_high", Trip, 1);
        check("stuck_still_set", Stuck, 2'b01);
        Trip_Raw = 1'b1;
        bad = 0;
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (Trip !== 1'b1) bad++;
            if (n < 0 && Stuck === 2'b00) n = i;
        end
        check_rng("stuck_clear_lat", n, 1, 15);
        check("stuck_rel_no_edge", bad, 0);
        check("stuck_cleared", Stuck, 2'b00);
`else
        step(200);
        check("hold_trip_low", Trip, 0);
        check("hold_no_stuck", Stuck, 2'b00);
        Trip_Raw = 1'b1;
        wait_sig(0, 1'b1, 40, n);
        check_rng("hold_rise_lat", n, 11, 15);
`endif
        step(5);

        // Asynchronous reset while Mode pressed
        Mode_Raw = 1'b0;
        step(20);
        check("pre_rst_mode", Mode, 0);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        check("async_rst_mode", Mode, 1);
        check("async_rst_trip", Trip, 1);
        check("async_rst_stuck", Stuck, 2'b00);
        @(negedge HCLK);
        HRESETn = 1'b1;
        wait_sig(1, 1'b0, 40, n);
        check_rng("refilter_fall_lat", n, 11, 15);
`ifdef STUCK_DETECT_EN
        step(40);
        check("pre_rst_stuck", Stuck, 2'b10);
        check("pre_rst_mode_forced", Mode, 1);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        check("async_rst_stuck2", Stuck, 2'b00);
        check("async_rst_mode2", Mode, 1);
        @(negedge HCLK);
        HRESETn = 1'b1;
`endif
        Mode_Raw = 1'b1;
        step(20);
        check("final_mode", Mode, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
